idu_imm_sequencer: RTL and testbench



---
 rtl/idu_seq_pkg.sv | 34 +++
 rtl/idu_seq_addr_gen.sv | 56 +++++
 rtl/idu_imm_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_idu_imm_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_seq_pkg.sv
// Shared constants, state type and command helpers for the immediate sequencer.
package idu_seq_pkg;

  localparam logic [3:0] CMD_NOP      = 4'b0000;
  localparam logic [3:0] CMD_IMM_6X1  = 4'b0100;
  localparam logic [3:0] CMD_IMM_6X2  = 4'b0101;
  localparam logic [3:0] CMD_IMM_12X1 = 4'b0110;
  localparam logic [3:0] CMD_IMM_12X2 = 4'b0111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } seq_state_e;

  // Column and row stride of one operand footprint.
  typedef struct packed {
    logic [1:0] col_step;
    logic [1:0] row_step;
  } footprint_t;

  // Wide (12-bit) operands take two columns; double-height ones step two rows.
  function automatic footprint_t cmd_footprint(input logic [3:0] cmd);
    footprint_t fp;
    fp.col_step = cmd[1] ? 2'd2 : 2'd1;
    fp.row_step = cmd[0] ? 2'd2 : 2'd1;
    return fp;
  endfunction

  // Only the four immediate-load encodings are accepted for issue.
  function automatic logic cmd_is_legal(input logic [3:0] cmd);
    return (cmd[3:2] == 2'b01);
  endfunction

endpackage

// File: rtl/idu_seq_addr_gen.sv
// Operand-ID stepper: presents the address of the beat being issued and
// advances it by the command footprint, wrapping column into row.
module idu_seq_addr_gen
  import idu_seq_pkg::*;
#(
  parameter int NUM_ROW = 32,
  parameter int NUM_COL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [3:0] cmd_i,
  input  logic [7:0] start_id_i,
  output logic [7:0] cur_id_o
);

  localparam logic [3:0] COL_LIMIT = 4'(NUM_COL);
  localparam logic [2:0] COL_MASK  = 3'(NUM_COL - 1);
  localparam logic [4:0] ROW_MASK  = 5'(NUM_ROW - 1);

  logic [7:0] cur_q, cur_d;
  logic [7:0] base_id;
  footprint_t fp;
  logic [3:0] col_sum;
  logic [4:0] row_cur, row_nxt;
  logic [2:0] col_nxt;

  // A first beat issues at its own start ID; later beats use the stored address.
  always_comb begin
    base_id = load_i ? start_id_i : cur_q;
    fp      = cmd_footprint(cmd_i);
    row_cur = base_id[7:3] & ROW_MASK;
    col_sum = {1'b0, base_id[2:0] & COL_MASK} + {2'b00, fp.col_step};
    if (col_sum >= COL_LIMIT) begin
      col_nxt = 3'(col_sum - COL_LIMIT);
      row_nxt = (row_cur + {3'b000, fp.row_step}) & ROW_MASK;
    end else begin
      col_nxt = col_sum[2:0];
      row_nxt = row_cur;
    end
    cur_d = (load_i || step_i) ? {row_nxt, col_nxt} : cur_q;
  end

  assign cur_id_o = base_id;

  // Address register; frozen whenever no beat is accepted (hold or bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= 8'h00;
    end else begin
      cur_q <= cur_d;
    end
  end

endmodule

// File: rtl/idu_imm_sequencer.sv
// Immediate-load sequencer: round-robin arbitration of two burst requesters
// and a registered broadcast of CMD/Operand_ID/DATA with one init per beat.
module idu_imm_sequencer
  import idu_seq_pkg::*;
#(
  parameter int NUM_ROW = 32,
  parameter int NUM_COL = 8
) (
  input  logic         sys_clk,
  input  logic         sys_resetb,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [3:0]   r0_cmd,
  input  logic [7:0]   r0_id,
  input  logic [3:0]   r0_count,
  input  logic [191:0] r0_data,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [3:0]   r1_cmd,
  input  logic [7:0]   r1_id,
  input  logic [3:0]   r1_count,
  input  logic [191:0] r1_data,
  input  logic         hold,
  output logic [3:0]   CMD,
  output logic [7:0]   Operand_ID,
  output logic [47:0]  DATA0_i,
  output logic [47:0]  DATA1_i,
  output logic [47:0]  DATA2_i,
  output logic [47:0]  DATA3_i,
  output logic         init,
  output logic         busy,
  output logic         err
);

  logic [1:0]   valid;
  logic [3:0]   req_cmd   [2];
  logic [7:0]   req_id    [2];
  logic [3:0]   req_count [2];
  logic [191:0] req_data  [2];

  assign valid        = {r1_valid, r0_valid};
  assign req_cmd[0]   = r0_cmd;
  assign req_cmd[1]   = r1_cmd;
  assign req_id[0]    = r0_id;
  assign req_id[1]    = r1_id;
  assign req_count[0] = r0_count;
  assign req_count[1] = r1_count;
  assign req_data[0]  = r0_data;
  assign req_data[1]  = r1_data;

  seq_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] bcmd_q, bcmd_d;

  logic       sel;
  logic [1:0] ready;
  logic       load, step, issue, err_d;
  logic [3:0] issue_cmd;
  logic [3:0] addr_cmd;
  logic [7:0] cur_id;

  logic [3:0]   iss_cmd_q;
  logic [7:0]   iss_id_q;
  logic [191:0] iss_data_q;
  logic         init_q, err_q;

  // Arbitration, burst control and beat acceptance.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    rem_d     = rem_q;
    bcmd_d    = bcmd_q;
    sel       = 1'b0;
    ready     = 2'b00;
    load      = 1'b0;
    step      = 1'b0;
    issue     = 1'b0;
    err_d     = 1'b0;
    issue_cmd = CMD_NOP;
    case (state_q)
      ST_IDLE: begin
        // Single valid requester wins outright; contention goes to rr.
        sel = (valid == 2'b11) ? rr_q : valid[1];
        if (!hold && valid[sel]) begin
          ready[sel] = 1'b1;
          if (cmd_is_legal(req_cmd[sel])) begin
            load      = 1'b1;
            issue     = 1'b1;
            issue_cmd = req_cmd[sel];
            bcmd_d    = req_cmd[sel];
            rem_d     = req_count[sel];
            if (req_count[sel] == 4'd0) begin
              rr_d = ~rr_q;
            end else begin
              state_d = ST_BURST;
              owner_d = sel;
            end
          end else begin
            // Illegal command is consumed and reported, never issued.
            err_d = 1'b1;
            rr_d  = ~rr_q;
          end
        end
      end
      ST_BURST: begin
        sel          = owner_q;
        ready[owner_q] = !hold;
        if (!hold && valid[owner_q]) begin
          step      = 1'b1;
          issue     = 1'b1;
          issue_cmd = bcmd_q;
          rem_d     = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = ST_IDLE;
            rr_d    = ~rr_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // First beat steps by its incoming command; later beats by the latched one.
  assign addr_cmd = load ? req_cmd[sel] : bcmd_q;

  idu_seq_addr_gen #(
    .NUM_ROW (NUM_ROW),
    .NUM_COL (NUM_COL)
  ) u_addr_gen (
    .clk        (sys_clk),
    .rst_n      (sys_resetb),
    .load_i     (load),
    .step_i     (step),
    .cmd_i      (addr_cmd),
    .start_id_i (req_id[sel]),
    .cur_id_o   (cur_id)
  );

  // Control state: FSM, burst owner, round-robin pointer, beat counter.
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      rem_q   <= 4'd0;
      bcmd_q  <= CMD_NOP;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      bcmd_q  <= bcmd_d;
    end
  end

  // Issue register: ID and data hold between beats, CMD returns to NOP.
  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      iss_cmd_q  <= CMD_NOP;
      iss_id_q   <= 8'h00;
      iss_data_q <= '0;
      init_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (issue) begin
        iss_cmd_q  <= issue_cmd;
        iss_id_q   <= cur_id;
        iss_data_q <= req_data[sel];
        init_q     <= 1'b1;
      end else begin
        iss_cmd_q <= CMD_NOP;
        init_q    <= 1'b0;
      end
    end
  end

  // Ready is masked while reset is asserted so no beat is handed over then.
  assign r0_ready   = ready[0] & sys_resetb;
  assign r1_ready   = ready[1] & sys_resetb;
  assign CMD        = iss_cmd_q;
  assign Operand_ID = iss_id_q;
  assign DATA0_i    = iss_data_q[47:0];
  assign DATA1_i    = iss_data_q[95:48];
  assign DATA2_i    = iss_data_q[143:96];
  assign DATA3_i    = iss_data_q[191:144];
  assign init       = init_q;
  assign err        = err_q;
  assign busy       = (state_q == ST_BURST);

endmodule

// File: tb/tb_idu_imm_sequencer.sv
// Randomized and directed bench for idu_imm_sequencer against a burst-level model.
module tb_idu_imm_sequencer;

  localparam int NR = 32;
  localparam int NC = 8;

  logic         sys_clk = 1'b0;
  logic         sys_resetb;
  logic         r0_valid, r0_ready, r1_valid, r1_ready;
  logic [3:0]   r0_cmd, r1_cmd, r0_count, r1_count;
  logic [7:0]   r0_id, r1_id;
  logic [191:0] r0_data, r1_data;
  logic         hold;
  logic [3:0]   CMD;
  logic [7:0]   Operand_ID;
  logic [47:0]  DATA0_i, DATA1_i, DATA2_i, DATA3_i;
  logic         init, busy, err;

  idu_imm_sequencer #(.NUM_ROW(NR), .NUM_COL(NC)) dut (
    .sys_clk    (sys_clk),
    .sys_resetb (sys_resetb),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_cmd     (r0_cmd),
    .r0_id      (r0_id),
    .r0_count   (r0_count),
    .r0_data    (r0_data),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_cmd     (r1_cmd),
    .r1_id      (r1_id),
    .r1_count   (r1_count),
    .r1_data    (r1_data),
    .hold       (hold),
    .CMD        (CMD),
    .Operand_ID (Operand_ID),
    .DATA0_i    (DATA0_i),
    .DATA1_i    (DATA1_i),
    .DATA2_i    (DATA2_i),
    .DATA3_i    (DATA3_i),
    .init       (init),
    .busy       (busy),
    .err        (err)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Requester-side stimulus state
  bit           has_b [2];
  logic [3:0]   b_cmd [2];
  logic [7:0]   b_id  [2];
  logic [3:0]   b_cnt [2];
  int           sent  [2];
  logic [191:0] b_data[2];
  bit           vld   [2];
  bit           rand_mode = 1'b0;

  // Reference model: owner of the running burst (-1 none), rr pointer and
  // the precomputed list of IDs the running burst has still to issue.
  int           m_owner;
  bit           m_rr;
  logic [7:0]   m_ids[$];
  logic [3:0]   m_cmd;
  logic         e_init, e_err, e_busy;
  logic [3:0]   e_cmd;
  logic [7:0]   e_id;
  logic [191:0] e_data;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [191:0] rand192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Next operand ID from the footprint rules, in plain row/column arithmetic.
  function automatic logic [7:0] next_id(input logic [7:0] id, input logic [3:0] c);
    int row, col, cs, rs;
    row = int'(id) / 8;
    col = int'(id) % 8;
    cs  = (c == 4'b0110 || c == 4'b0111) ? 2 : 1;
    rs  = (c == 4'b0101 || c == 4'b0111) ? 2 : 1;
    col = col + cs;
    if (col >= NC) begin
      col = col - NC;
      row = (row + rs) % NR;
    end
    return 8'(row * 8 + col);
  endfunction

  task automatic apply_inputs();
    r0_valid = vld[0]; r0_cmd = b_cmd[0]; r0_id = b_id[0]; r0_count = b_cnt[0]; r0_data = b_data[0];
    r1_valid = vld[1]; r1_cmd = b_cmd[1]; r1_id = b_id[1]; r1_count = b_cnt[1]; r1_data = b_data[1];
  endtask

  task automatic load_burst(input int r, input logic [3:0] c, input logic [7:0] id, input logic [3:0] n);
    has_b[r]  = 1'b1;
    b_cmd[r]  = c;
    b_id[r]   = id;
    b_cnt[r]  = n;
    sent[r]   = 0;
    b_data[r] = rand192();
    vld[r]    = 1'b1;
    apply_inputs();
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_init"}, 192'(init), 192'(e_init));
    chk({ph, "_cmd"},  192'(CMD), 192'(e_cmd));
    chk({ph, "_id"},   192'(Operand_ID), 192'(e_id));
    chk({ph, "_data"}, {DATA3_i, DATA2_i, DATA1_i, DATA0_i}, e_data);
    chk({ph, "_err"},  192'(err), 192'(e_err));
    chk({ph, "_busy"}, 192'(busy), 192'(e_busy));
  endtask

  // Called at posedge+1 with reset released; asserts reset between edges.
  task automatic do_reset();
    sys_resetb = 1'b0;
    #1;
    m_owner = -1; m_rr = 1'b0; m_ids.delete(); m_cmd = 4'd0;
    e_init = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_cmd = 4'd0; e_id = 8'd0; e_data = '0;
    for (int r = 0; r < 2; r++) sent[r] = 0;
    check_outputs("rst");
    chk("rst_ready0", 192'(r0_ready), 192'(0));
    chk("rst_ready1", 192'(r1_ready), 192'(0));
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_resetb = 1'b1;
    for (int r = 0; r < 2; r++) vld[r] = has_b[r];
    apply_inputs();
  endtask

  // One clock: check ready mid-cycle, predict, check registered outputs.
  task automatic cycle();
    int w;
    logic [1:0] er;
    bit acc, legal;
    logic [7:0] a;
    @(negedge sys_clk);
    w  = -1;
    er = 2'b00;
    if (m_owner < 0) begin
      if (!hold) begin
        if (vld[0] && vld[1]) w = int'(m_rr);
        else if (vld[0]) w = 0;
        else if (vld[1]) w = 1;
        if (w >= 0) er[w] = 1'b1;
      end
    end else begin
      w = m_owner;
      er[w] = !hold;
    end
    chk("ready0", 192'(r0_ready), 192'(er[0]));
    chk("ready1", 192'(r1_ready), 192'(er[1]));
    acc    = (w >= 0) && er[w] && vld[w];
    legal  = 1'b0;
    e_init = 1'b0;
    e_cmd  = 4'd0;
    e_err  = 1'b0;
    if (acc) begin
      legal = (b_cmd[w] inside {[4'd4:4'd7]});
      if (m_owner < 0) begin
        if (legal) begin
          m_cmd   = b_cmd[w];
          m_owner = w;
          m_ids.delete();
          a = b_id[w];
          for (int k = 0; k <= int'(b_cnt[w]); k++) begin
            m_ids.push_back(a);
            a = next_id(a, b_cmd[w]);
          end
        end else begin
          e_err = 1'b1;
          m_rr  = ~m_rr;
          $display("drop r%0d cmd=%h", w, b_cmd[w]);
        end
      end
      if (legal && m_owner == w) begin
        e_init = 1'b1;
        e_cmd  = m_cmd;
        e_id   = m_ids.pop_front();
        e_data = b_data[w];
        $display("beat r%0d cmd=%h id=%h left=%0d", w, m_cmd, e_id, m_ids.size());
        if (m_ids.size() == 0) begin
          m_owner = -1;
          m_rr    = ~m_rr;
        end
      end
    end
    e_busy = (m_owner >= 0);
    @(posedge sys_clk);
    #1;
    check_outputs("out");
    if (acc) begin
      sent[w]++;
      if (!legal || sent[w] > int'(b_cnt[w])) has_b[w] = 1'b0;
      b_data[w] = rand192();
    end
    for (int r = 0; r < 2; r++) begin
      if (!has_b[r] && rand_mode && $urandom_range(0, 99) < 30) begin
        has_b[r] = 1'b1;
        b_cmd[r] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 7));
        b_id[r]  = 8'($urandom);
        b_cnt[r] = 4'($urandom_range(0, 5));
        sent[r]  = 0;
      end
      vld[r] = has_b[r] && (sent[r] == 0 || !rand_mode || $urandom_range(0, 99) < 80);
    end
    if (rand_mode) hold = ($urandom_range(0, 99) < 15);
    apply_inputs();
  endtask

  initial begin
    bit reloaded;
    sys_resetb = 1'b1;
    hold = 1'b0;
    for (int r = 0; r < 2; r++) begin
      has_b[r] = 1'b0; b_cmd[r] = 4'd0; b_id[r] = 8'd0; b_cnt[r] = 4'd0;
      sent[r] = 0; b_data[r] = '0; vld[r] = 1'b0;
    end
    apply_inputs();
    #2;
    do_reset();

    // 6x1 burst of 4 from row 0, col 0
    load_burst(0, 4'b0100, 8'h00, 4'd3);
    for (int i = 0; i < 6; i++) cycle();

    // 12x2 from {row 2, col 6}: column wrap with a row step of 2
    load_burst(1, 4'b0111, {5'd2, 3'd6}, 4'd1);
    for (int i = 0; i < 4; i++) cycle();

    // contention from reset, then r0 re-presents right after its last beat
    do_reset();
    load_burst(0, 4'b0110, 8'h41, 4'd2);
    load_burst(1, 4'b0101, 8'h87, 4'd2);
    reloaded = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (!has_b[0] && !reloaded) begin
        load_burst(0, 4'b0101, 8'h30, 4'd1);
        reloaded = 1'b1;
      end
    end

    // illegal command dropped, followed by contention to expose rr
    load_burst(0, 4'b0011, 8'h12, 4'd2);
    for (int i = 0; i < 2; i++) cycle();
    load_burst(0, 4'b0100, 8'h07, 4'd0);
    load_burst(1, 4'b0100, 8'h17, 4'd0);
    for (int i = 0; i < 4; i++) cycle();

    // 2-cycle hold inside a 4-beat 12x1 burst
    load_burst(0, 4'b0110, 8'h16, 4'd3);
    cycle();
    cycle();
    hold = 1'b1;
    cycle();
    cycle();
    hold = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // reset on beat 2 of 4, then the burst re-issues from its start ID
    load_burst(1, 4'b0101, 8'h3e, 4'd3);
    cycle();
    cycle();
    do_reset();
    for (int i = 0; i < 6; i++) cycle();

    // randomized traffic with holds, bubbles and illegal commands
    rand_mode = 1'b1;
    for (int i = 0; i < 2500; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
